key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// Purpose : classify a debounced key into short / long / auto-repeat / double-click events.
// Latency : every output is registered; a pulse rises on the same clk edge as its triggering FSM transition.
// Backpr. : none; free-running and driven purely by the key level, outputs cannot be stalled.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst_n        synchronous active-low reset
//   key_in       debounced key level, 0 = pressed, 1 = released
//   short_pulse  one-cycle pulse for a completed short press
//   long_pulse   one-cycle pulse when a press reaches LONG_TIME cycles
//   repeat_pulse one-cycle pulse every REPEAT_TIME cycles while a long press is held
//   double_pulse one-cycle pulse for a completed double click (constant 0 without the macro)
//   key_held     level, high while in PRESS, HOLD or PRESS2
//
// Build option: define KEY_DOUBLE_CLICK_EN to add double-click detection (WAIT2/PRESS2).
// With it, a short press is only reported once the DCLICK_TIME window has expired.

module key_event_decoder #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int DCLICK_TIME = 15_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic key_held
);

  // One counter is shared by all timed states, so it is sized for the longest interval.
  localparam int MAX_LR = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
  localparam int MAX_T  = (MAX_LR > DCLICK_TIME) ? MAX_LR : DCLICK_TIME;
  localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TIME - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_HOLD   = 3'd2
`ifdef KEY_DOUBLE_CLICK_EN
    ,
    S_WAIT2  = 3'd3,
    S_PRESS2 = 3'd4
`endif
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_d;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_key_held;
`ifdef KEY_DOUBLE_CLICK_EN
  logic             r_double;
`endif

  // r_key_d resets to 0, so a key held low across reset release never looks like a fresh press.
  logic w_press_edge;
  logic w_release;
  assign w_press_edge = r_key_d & ~key_in;
  assign w_release    = key_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_key_d    <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_key_held <= 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
      r_double   <= 1'b0;
`endif
    end else begin
      r_key_d  <= key_in;
      // Pulses are high only on the edge that performs their transition.
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
      r_double <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_press_edge) begin
            r_state    <= S_PRESS;
            r_cnt      <= '0;
            r_key_held <= 1'b1;
          end
        end

        S_PRESS: begin
          // Release wins over the long threshold: long needs the key still down.
          if (w_release) begin
`ifdef KEY_DOUBLE_CLICK_EN
            r_state    <= S_WAIT2;
`else
            r_state    <= S_IDLE;
            r_short    <= 1'b1;
`endif
            r_cnt      <= '0;
            r_key_held <= 1'b0;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          // Ending a long press is silent.
          if (w_release) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key_held <= 1'b0;
          end else if (r_cnt == REPEAT_LAST) begin
            r_cnt    <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef KEY_DOUBLE_CLICK_EN
        S_WAIT2: begin
          // A second press on the timeout cycle still counts as a double click.
          if (w_press_edge) begin
            r_state    <= S_PRESS2;
            r_cnt      <= '0;
            r_key_held <= 1'b1;
          end else if (r_cnt == DCLICK_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PRESS2: begin
          // No timing here: the second click never turns into a long press.
          if (w_release) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key_held <= 1'b0;
            r_double   <= 1'b1;
          end
        end
`endif

        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;
  assign key_held     = r_key_held;
`ifdef KEY_DOUBLE_CLICK_EN
  assign double_pulse = r_double;
`else
  assign double_pulse = 1'b0;
`endif

endmodule
